config_loader: RTL and testbench

Bitstream loader that drives the serial configuration chain of the fabric tiles. It accepts parallel configuration words from a host-side source over a valid/ready handshake and serializes them MSB-first onto the chain's serial data input, qualified by a per-bit shift enable. It counts bits against the chain length and signals completion. It is the writing end of the tile configuration shift chain and sits between the configuration port and the first tile of the chain.

---
 rtl/config_pkg.sv | 17 +
 rtl/config_loader.sv | 121 ++++++++++++
 tb/tb_config_loader.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/config_pkg.sv
// Shared definitions for the tile configuration chain: loader FSM states
// and the counter width helper.
package config_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } cfg_state_e;

  // Bits needed for a down-counter that must hold values 0..max_count.
  function automatic int unsigned cnt_width(input int unsigned max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/config_loader.sv
// Configuration bitstream loader: accepts host words over valid/ready and
// shifts them MSB-first into the tile configuration chain, counting bits
// against the chain length and pulsing done after the final bit.
import config_pkg::*;

module config_loader #(
  parameter int unsigned WORD_WIDTH   = 32,
  parameter int unsigned CHAIN_LENGTH = 1024
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  word_valid,
  input  logic [WORD_WIDTH-1:0] word_data,
  output logic                  word_ready,
  output logic                  config_enable,
  output logic                  config_data,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned REM_W = cnt_width(CHAIN_LENGTH);
  localparam int unsigned BIT_W = cnt_width(WORD_WIDTH);

  cfg_state_e            state_q;
  logic [WORD_WIDTH-1:0] shift_q;
  logic [REM_W-1:0]      rem_q;
  logic [BIT_W-1:0]      bit_q;
  logic                  ready_q;
  logic                  enable_q;
  logic                  busy_q;
  logic                  done_q;

  logic [BIT_W-1:0]      word_bits_d;

  // Bits to shift from the next word: a full word, or only the remaining
  // bits when the chain ends part-way through it.
  always_comb begin
    word_bits_d = BIT_W'(WORD_WIDTH);
    if (32'(rem_q) < WORD_WIDTH) begin
      word_bits_d = BIT_W'(rem_q);
    end
  end

  // Loader FSM with shift register, counters and registered outputs.
  // Output flags are set on the edge that enters a state so they line up
  // with the state register without any decode from inputs.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      rem_q    <= '0;
      bit_q    <= '0;
      ready_q  <= 1'b0;
      enable_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (abort) begin
      state_q  <= IDLE;
      ready_q  <= 1'b0;
      enable_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          rem_q <= REM_W'(CHAIN_LENGTH);
          if (start) begin
            state_q <= LOAD;
            ready_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        LOAD: begin
          if (word_valid && ready_q) begin
            shift_q  <= word_data;
            bit_q    <= word_bits_d;
            state_q  <= SHIFT;
            ready_q  <= 1'b0;
            enable_q <= 1'b1;
          end
        end
        SHIFT: begin
          shift_q <= {shift_q[WORD_WIDTH-2:0], 1'b0};
          bit_q   <= bit_q - BIT_W'(1);
          rem_q   <= rem_q - REM_W'(1);
          if (bit_q == BIT_W'(1)) begin
            enable_q <= 1'b0;
            if (rem_q == REM_W'(1)) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= LOAD;
              ready_q <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q  <= IDLE;
          ready_q  <= 1'b0;
          enable_q <= 1'b0;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
        end
      endcase
    end
  end

  assign word_ready    = ready_q;
  assign config_enable = enable_q;
  assign config_data   = shift_q[WORD_WIDTH-1];
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_config_loader.sv
// Directed bench for config_loader with an 8-bit word and a 20-bit chain.
module tb_config_loader;

  localparam int unsigned WW = 8;
  localparam int unsigned CL = 20;

  logic          clock = 1'b0;
  logic          nreset;
  logic          start;
  logic          abort;
  logic          word_valid;
  logic [WW-1:0] word_data;
  logic          word_ready;
  logic          config_enable;
  logic          config_data;
  logic          busy;
  logic          done;

  config_loader #(
    .WORD_WIDTH  (WW),
    .CHAIN_LENGTH(CL)
  ) dut (
    .clock        (clock),
    .nreset       (nreset),
    .start        (start),
    .abort        (abort),
    .word_valid   (word_valid),
    .word_data    (word_data),
    .word_ready   (word_ready),
    .config_enable(config_enable),
    .config_data  (config_data),
    .busy         (busy),
    .done         (done)
  );

  always #5 clock = ~clock;

  int n_run  = 0;
  int n_fail = 0;

  bit          exp_q[$];
  logic [CL-1:0] chain = '0;
  int          cyc      = 0;
  int          en_cnt   = 0;
  int          done_cnt = 0;
  int          last_en  = 0;
  int          done_at  = 0;
  logic [WW-1:0] words [3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and observe the chain side there.
  task automatic tick();
    bit e;
    @(negedge clock);
    cyc++;
    if (config_enable === 1'b1) begin
      en_cnt++;
      last_en = cyc;
      chain = {chain[CL-2:0], config_data};
      check("sb_underflow", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("serial_bit", 32'(config_data), 32'(e));
      end
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_at = cyc;
    end
  endtask

  task automatic send_word(input logic [WW-1:0] w, input int stall, input int nb);
    int k;
    word_data  = w;
    word_valid = (stall == 0);
    k = 0;
    while (word_ready !== 1'b1 && k < 100) begin
      tick();
      k++;
    end
    check("handshake_wait", 32'(word_ready), 32'd1);
    for (int s = 0; s < stall; s++) begin
      check("stall_ready", 32'(word_ready), 32'd1);
      check("stall_enable", 32'(config_enable), 32'd0);
      tick();
    end
    word_valid = 1'b1;
    for (int i = WW - 1; i >= int'(WW) - nb; i--) exp_q.push_back(w[i]);
    tick();
    word_valid = 1'b0;
    word_data  = WW'($urandom);
  endtask

  task automatic run_load(input int stall, input bit extra_start);
    int en0, d0, t0, rem, nb, k;
    en0 = en_cnt;
    d0  = done_cnt;
    rem = CL;
    start = 1'b1;
    tick();
    start = 1'b0;
    t0 = cyc;
    check("load_ready", 32'(word_ready), 32'd1);
    check("load_busy", 32'(busy), 32'd1);
    for (int w = 0; w < 3; w++) begin
      nb = (rem < int'(WW)) ? rem : int'(WW);
      rem -= nb;
      send_word(words[w], (w == 1) ? stall : 0, nb);
      if (extra_start && w == 0) begin
        start = 1'b1;
        tick();
        start = 1'b0;
      end
    end
    k = 0;
    while (done_cnt == d0 && k < 100) begin
      tick();
      k++;
    end
    check("done_seen", 32'(done_cnt - d0), 32'd1);
    check("done_after_last", 32'(done_at - last_en), 32'd1);
    check("busy_in_done", 32'(busy), 32'd1);
    check("load_span", 32'(last_en - t0 + 1), 32'(23 + stall));
    tick();
    check("done_pulse", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_ready", 32'(word_ready), 32'd0);
    tick();
    tick();
    check("done_once", 32'(done_cnt - d0), 32'd1);
    check("enable_count", 32'(en_cnt - en0), CL);
    check("chain_value", 32'(chain), 32'h000A53CF);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int en0, d0;
    words[0] = 8'hA5;
    words[1] = 8'h3C;
    words[2] = 8'hF0;
    nreset     = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    word_valid = 1'b0;
    word_data  = '0;

    // Reset values while held and after release.
    tick();
    tick();
    check("rst_ready", 32'(word_ready), 32'd0);
    check("rst_enable", 32'(config_enable), 32'd0);
    check("rst_data", 32'(config_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    nreset = 1'b1;
    tick();
    tick();
    check("post_rst_ready", 32'(word_ready), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_enable", 32'(config_enable), 32'd0);

    // Full load, zero-wait host.
    run_load(0, 1'b0);

    // Host stall of five cycles before the second word.
    run_load(5, 1'b0);

    // Abort in the third SHIFT cycle of word 2.
    en0 = en_cnt;
    d0  = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    send_word(words[0], 0, 8);
    send_word(words[1], 0, 8);
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_enable", 32'(config_enable), 32'd0);
    check("abort_ready", 32'(word_ready), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_bits", 32'(en_cnt - en0), 32'd11);
    check("abort_leftover", 32'(exp_q.size()), 32'd5);
    exp_q.delete();
    tick();
    tick();
    tick();
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    run_load(0, 1'b0);

    // Start pulsed during SHIFT is ignored.
    run_load(0, 1'b1);

    // Asynchronous reset between edges during SHIFT.
    start = 1'b1;
    tick();
    start = 1'b0;
    send_word(words[0], 0, 8);
    tick();
    check("pre_arst_enable", 32'(config_enable), 32'd1);
    #2 nreset = 1'b0;
    #1;
    check("arst_enable", 32'(config_enable), 32'd0);
    check("arst_data", 32'(config_data), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_ready", 32'(word_ready), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    #1 nreset = 1'b1;
    exp_q.delete();
    tick();
    check("arst_idle_busy", 32'(busy), 32'd0);
    run_load(0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
